// File: rtl/um_alu_issue.sv
// Issue/writeback controller for the UM alu: reads B/C operands, pulses the alu start,
// waits for completion and writes the result to register A; traps div0, illegal ops and alu hangs.
`timescale 1ns/1ps
module um_alu_issue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              r,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [2:0]        rb_addr,
  output logic [2:0]        rc_addr,
  input  logic [DATA_W-1:0] rb_data,
  input  logic [DATA_W-1:0] rc_data,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_s,
  output logic              alu_r,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_finished,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_x_q, alu_x_d;
  logic [DATA_W-1:0]   alu_y_q, alu_y_d;
  logic [1:0]          alu_s_q, alu_s_d;
  logic                alu_r_q, alu_r_d;
  logic                wr_en_q, wr_en_d;
  logic [2:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                in_ready_q, in_ready_d;

  logic [3:0] opcode;
  logic       unused_instr;

  assign opcode       = in_instr[31:28];
  assign rb_addr      = in_instr[5:3];
  assign rc_addr      = in_instr[2:0];
  assign unused_instr = ^in_instr[27:9];

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_s_d    = alu_s_q;
    alu_r_d    = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode >= 4'd3 && opcode <= 4'd6) begin
            alu_x_d   = rb_data;
            alu_y_d   = rc_data;
            alu_s_d   = 2'(opcode - 4'd3);
            wr_addr_d = in_instr[8:6];
            if (opcode == 4'd5 && rc_data == '0) begin
              state_d    = S_ERROR;
              err_code_d = ERR_DIV0;
            end else begin
              state_d = S_ISSUE;
              alu_r_d = 1'b1;
            end
          end else begin
            state_d    = S_ERROR;
            err_code_d = ERR_ILLEGAL;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_finished) begin
          wr_data_d = alu_out;
          wr_en_d   = 1'b1;
          state_d   = S_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_s_q    <= '0;
      alu_r_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_s_q    <= alu_s_d;
      alu_r_q    <= alu_r_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_s    = alu_s_q;
  assign alu_r    = alu_r_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: doc/um_alu_issue.md
Name: um_alu_issue

Overview:
Issue/writeback controller that sits directly upstream of the UM alu and feeds it. It accepts UM arithmetic instructions: opcodes 3 add, 4 mul, 5 div and 6 nand. It reads operands B and C from the register file and starts the alu with a one-cycle start pulse. It then waits for the alu's finished flag and writes the result to register A. It also traps divide-by-zero, illegal opcodes and a hung alu.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 80, maximum WAIT cycles before a timeout error; must be at least 2

Ports:
clk  in  1  system clock
r  in  1  reset, asynchronous, active-low (asserted when r==0)
in_valid  in  1  instruction offered
in_ready  out  1  block can accept an instruction
in_instr  in  32  UM word: opcode [31:28], A [8:6], B [5:3], C [2:0]
rb_addr  out  3  regfile read addr B = in_instr[5:3], combinational
rc_addr  out  3  regfile read addr C = in_instr[2:0], combinational
rb_data  in  DATA_W  regfile read data B, combinational
rc_data  in  DATA_W  regfile read data C, combinational
alu_x  out  DATA_W  latched B operand
alu_y  out  DATA_W  latched C operand
alu_s  out  2  alu select: op3→00, op4→01, op5→10, op6→11
alu_r  out  1  alu start/clear pulse, active-high
alu_out  in  DATA_W  alu result
alu_finished  in  1  alu done
wr_en  out  1  regfile write strobe, one cycle
wr_addr  out  3  destination A
wr_data  out  DATA_W  result
busy  out  1  state is not IDLE
err  out  1  sticky error
err_code  out  2  00 none, 01 div0, 10 timeout, 11 illegal opcode

Behaviour:
- Reset (r==0, asynchronous):
  - state goes to IDLE.
  - All registers and outputs clear to 0 (alu_x, alu_y, alu_s, alu_r, wr_en, wr_addr, wr_data, busy, err, err_code, counter).
  - in_ready=1 once reset is released.
  - An in-flight operation is discarded with no writeback.
- States: IDLE, ISSUE, WAIT, WRITE, ERROR.
- IDLE (in_ready=1):
  - On clock edge with in_valid=1 and opcode in 3..6: latch alu_x←rb_data, alu_y←rc_data, alu_s, wr_addr←A.
  - If opcode==5 and rc_data==0: go to ERROR with err_code=01.
  - Otherwise go to ISSUE.
  - in_valid=1 with any other opcode: instruction consumed, go to ERROR with err_code=11.
- ISSUE: alu_r=1 for exactly this cycle; clear counter; go to WAIT.
- WAIT:
  - alu_r=0; alu_finished is sampled only in this state.
  - alu_finished=1: capture wr_data←alu_out, go to WRITE.
  - Else if counter==TIMEOUT-1: go to ERROR with err_code=10.
  - Else counter++.
- WRITE: wr_en=1 for one cycle; go to IDLE.
- ERROR: err=1, in_ready=0, no writes; held until reset.
- in_ready is high only in IDLE; busy = !IDLE.
- Latency for add/nand (alu_finished already high):
  - Accept edge at T0; alu_r high during T1.
  - Capture at the end of the first WAIT cycle T2; wr_en high during T3.
  - Next accept possible at the end of T4.
  - Multi-cycle ops add one cycle per extra WAIT cycle.
- alu_x, alu_y and alu_s stay stable from the accept edge until the next accept.
- Arithmetic is performed by the alu. Results are modulo 2^DATA_W; mul writes the low word.
- Simultaneous in_valid and reset: reset wins, nothing is accepted.
- alu_finished high in ISSUE is ignored.

Test Plan:
- add: B=0xFFFFFFFF, C=2, A=5 → alu_r one cycle; wr_en 3 cycles after accept, wr_addr=5, wr_data=0x00000001.
- mul: B=0x00010000, C=0x00010003, alu model finishes after 33 cycles → single wr_en with low word 0x00030000; busy throughout; no second alu_r.
- div: B=100, C=7, alu model finishes after 66 cycles → wr_data=14. Separately C=0 → err=1, err_code=01, alu_r and wr_en never assert, in_ready stays 0.
- timeout: op 4, alu_finished held 0 → after TIMEOUT WAIT cycles err_code=10, no wr_en.
- illegal: opcode 7 with in_valid=1 → err_code=11, alu_r never asserts. Drop r to 0 → err=0, in_ready=1.
- reset mid-op: drop r during WAIT of a mul → all outputs 0 immediately, no wr_en. After release, an add B=3, C=4 completes with wr_data=7.
